// File: rtl/n_bit_div.sv
// Unsigned restoring divider: one quotient bit per cycle, MSB first, valid/ready on both sides.
// Define N_BIT_DIV_ZERO_DET_EN to add the div_zero output and a one-cycle divide-by-zero shortcut.
module n_bit_div #(
  parameter int BIT_DEPTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [BIT_DEPTH-1:0] a,
  input  logic [BIT_DEPTH-1:0] b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [BIT_DEPTH-1:0] q,
  output logic [BIT_DEPTH-1:0] r
`ifdef N_BIT_DIV_ZERO_DET_EN
  ,
  output logic                 div_zero
`endif
);

  localparam int CW = (BIT_DEPTH > 2) ? $clog2(BIT_DEPTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(BIT_DEPTH - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_e;

  state_e               state_q, state_d;
  logic [BIT_DEPTH-1:0] dvd_q, dvd_d;
  logic [BIT_DEPTH-1:0] dvs_q, dvs_d;
  logic [BIT_DEPTH-1:0] rem_q, rem_d;
  logic [BIT_DEPTH-1:0] quo_q, quo_d;
  logic [BIT_DEPTH-1:0] q_q, q_d;
  logic [BIT_DEPTH-1:0] r_q, r_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [BIT_DEPTH:0]   shifted, diff;
  logic [BIT_DEPTH-1:0] rem_step, quo_step;
  logic                 finish;
`ifdef N_BIT_DIV_ZERO_DET_EN
  logic                 dz_q, dz_d;
`endif

  // A borrow out of the BIT_DEPTH+1-bit difference means the trial subtraction went negative.
  always_comb begin
    shifted  = {rem_q, dvd_q[BIT_DEPTH-1]};
    diff     = shifted - {1'b0, dvs_q};
    rem_step = diff[BIT_DEPTH] ? shifted[BIT_DEPTH-1:0] : diff[BIT_DEPTH-1:0];
    quo_step = {quo_q[BIT_DEPTH-2:0], ~diff[BIT_DEPTH]};
  end

`ifdef N_BIT_DIV_ZERO_DET_EN
  assign finish = (state_q == CALC) && ((cnt_q == LAST) || dz_q);
`else
  assign finish = (state_q == CALC) && (cnt_q == LAST);
`endif

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid)  state_d = CALC;
      CALC:    if (finish)    state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
  end

  always_comb begin
    dvd_d = dvd_q;
    dvs_d = dvs_q;
    rem_d = rem_q;
    quo_d = quo_q;
    cnt_d = cnt_q;
    q_d   = q_q;
    r_d   = r_q;
`ifdef N_BIT_DIV_ZERO_DET_EN
    dz_d  = dz_q;
`endif
    if (state_q == IDLE && in_valid) begin
      dvd_d = a;
      dvs_d = b;
      rem_d = '0;
      quo_d = '0;
      cnt_d = '0;
`ifdef N_BIT_DIV_ZERO_DET_EN
      dz_d  = (b == '0);
`endif
    end else if (state_q == CALC) begin
      dvd_d = dvd_q << 1;
      rem_d = rem_step;
      quo_d = quo_step;
      cnt_d = cnt_q + CW'(1);
      if (finish) begin
        q_d = quo_step;
        r_d = rem_step;
`ifdef N_BIT_DIV_ZERO_DET_EN
        // Shortcut exits on the first CALC edge, so the dividend register still holds a.
        if (dz_q) begin
          q_d = '1;
          r_d = dvd_q;
        end
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dvd_q <= '0;
      dvs_q <= '0;
      rem_q <= '0;
      quo_q <= '0;
      cnt_q <= '0;
      q_q   <= '0;
      r_q   <= '0;
`ifdef N_BIT_DIV_ZERO_DET_EN
      dz_q  <= 1'b0;
`endif
    end else begin
      dvd_q <= dvd_d;
      dvs_q <= dvs_d;
      rem_q <= rem_d;
      quo_q <= quo_d;
      cnt_q <= cnt_d;
      q_q   <= q_d;
      r_q   <= r_d;
`ifdef N_BIT_DIV_ZERO_DET_EN
      dz_q  <= dz_d;
`endif
    end
  end

  assign q = q_q;
  assign r = r_q;
`ifdef N_BIT_DIV_ZERO_DET_EN
  assign div_zero = dz_q & out_valid;
`endif

endmodule

// File: tb/tb_n_bit_div.sv
// Bench for n_bit_div: 8-bit and 32-bit instances checked against an arithmetic
// quotient/remainder model with directed and randomized transactions.
module tb_n_bit_div;

`ifdef N_BIT_DIV_ZERO_DET_EN
  localparam bit ZD = 1'b1;
`else
  localparam bit ZD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ordy;
  logic        iv8, ir8, ov8;
  logic [7:0]  a8, b8, q8, r8;
  logic        iv32, ir32, ov32;
  logic [31:0] a32, b32, q32, r32;
  logic        dz8, dz32;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  n_bit_div #(.BIT_DEPTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8),
    .out_valid(ov8), .out_ready(ordy), .q(q8), .r(r8)
`ifdef N_BIT_DIV_ZERO_DET_EN
    , .div_zero(dz8)
`endif
  );

  n_bit_div #(.BIT_DEPTH(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv32), .in_ready(ir32), .a(a32), .b(b32),
    .out_valid(ov32), .out_ready(ordy), .q(q32), .r(r32)
`ifdef N_BIT_DIV_ZERO_DET_EN
    , .div_zero(dz32)
`endif
  );

`ifndef N_BIT_DIV_ZERO_DET_EN
  assign dz8  = 1'b0;
  assign dz32 = 1'b0;
`endif

  function automatic logic [31:0] get_q(input bit wide);
    return wide ? q32 : {24'h0, q8};
  endfunction
  function automatic logic [31:0] get_r(input bit wide);
    return wide ? r32 : {24'h0, r8};
  endfunction
  function automatic logic get_ov(input bit wide);
    return wide ? ov32 : ov8;
  endfunction
  function automatic logic get_ir(input bit wide);
    return wide ? ir32 : ir8;
  endfunction
  function automatic logic get_dz(input bit wide);
    return wide ? dz32 : dz8;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit wide, input logic [31:0] av, input logic [31:0] bv, input logic v);
    if (wide) begin
      a32 = av; b32 = bv; iv32 = v;
    end else begin
      a8 = av[7:0]; b8 = bv[7:0]; iv8 = v;
    end
  endtask

  // One full transaction; rnd scrambles operands/in_valid while busy, hold stalls out_ready.
  task automatic xact(input bit wide, input logic [31:0] av, input logic [31:0] bv,
                      input int hold, input bit rnd, input string tag);
    int          w, lat, n;
    logic [31:0] m, ea, eb, eq, er;
    w  = wide ? 32 : 8;
    m  = wide ? 32'hFFFF_FFFF : 32'h0000_00FF;
    ea = av & m;
    eb = bv & m;
    eq = (eb == 0) ? m : ea / eb;
    er = (eb == 0) ? ea : ea % eb;
    lat = (eb == 0 && ZD) ? 1 : w;
    ordy = (hold == 0);
    n = 0;
    while (!get_ir(wide) && n < 100) begin
      step();
      n++;
    end
    check({tag, " in_ready before"}, 32'(get_ir(wide)), 32'd1);
    drive(wide, ea, eb, 1'b1);
    step();
    if (rnd) drive(wide, $urandom, $urandom, 1'b1);
    else     drive(wide, ea, eb, 1'b0);
    n = 0;
    while (!get_ov(wide) && n < w + 4) begin
      check({tag, " in_ready busy"}, 32'(get_ir(wide)), 32'd0);
      if (rnd) drive(wide, $urandom, $urandom, 1'($urandom));
      step();
      n++;
    end
    check({tag, " latency"}, 32'(n), 32'(lat));
    check({tag, " out_valid"}, 32'(get_ov(wide)), 32'd1);
    check({tag, " q"}, get_q(wide), eq);
    check({tag, " r"}, get_r(wide), er);
    if (ZD) check({tag, " div_zero"}, 32'(get_dz(wide)), 32'(eb == 0));
    if (rnd) drive(wide, $urandom, $urandom, 1'b1);
    for (int i = 0; i < hold; i++) begin
      step();
      check({tag, " hold out_valid"}, 32'(get_ov(wide)), 32'd1);
      check({tag, " hold q"}, get_q(wide), eq);
      check({tag, " hold r"}, get_r(wide), er);
      check({tag, " hold in_ready"}, 32'(get_ir(wide)), 32'd0);
    end
    ordy = 1'b1;
    drive(wide, ea, eb, 1'b0);
    step();
    check({tag, " out_valid drop"}, 32'(get_ov(wide)), 32'd0);
    check({tag, " in_ready rise"}, 32'(get_ir(wide)), 32'd1);
    check({tag, " q kept"}, get_q(wide), eq);
    check({tag, " r kept"}, get_r(wide), er);
    step();
    check({tag, " single result"}, 32'(get_ov(wide)), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          stray;
    bit          wide;
    logic [31:0] av, bv;

    rst_n = 1'b0;
    ordy  = 1'b1;
    drive(1'b0, 0, 0, 1'b0);
    drive(1'b1, 0, 0, 1'b0);
    step();
    step();
    check("reset q8", {24'h0, q8}, 32'd0);
    check("reset r8", {24'h0, r8}, 32'd0);
    check("reset out_valid", 32'(ov8), 32'd0);
    check("reset q32", q32, 32'd0);
    rst_n = 1'b1;
    check("reset in_ready", 32'(ir8), 32'd1);

    xact(1'b0, 100, 7, 0, 1'b0, "d100_7");
    xact(1'b0, 255, 1, 0, 1'b0, "d255_1");
    xact(1'b0, 5, 10, 0, 1'b0, "d5_10");
    xact(1'b0, 0, 3, 0, 1'b0, "d0_3");
    xact(1'b1, 32'hFFFF_FFFF, 32'h0001_0000, 5, 1'b0, "w_ffff");
    xact(1'b0, 37, 0, 0, 1'b0, "d37_0");

    // Abort an operation after four CALC cycles; outputs must clear without a clock.
    drive(1'b0, 200, 9, 1'b1);
    step();
    drive(1'b0, 200, 9, 1'b0);
    repeat (4) step();
    #2 rst_n = 1'b0;
    #1;
    check("abort q", {24'h0, q8}, 32'd0);
    check("abort r", {24'h0, r8}, 32'd0);
    check("abort out_valid", 32'(ov8), 32'd0);
    check("abort in_ready", 32'(ir8), 32'd1);
    step();
    rst_n = 1'b1;
    stray = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (ov8) stray++;
    end
    check("abort no result", 32'(stray), 32'd0);
    xact(1'b0, 20, 6, 0, 1'b0, "d20_6");

    // Operands presented while reset releases are taken on the very next edge.
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    xact(1'b0, 77, 5, 0, 1'b0, "post_rst");

    for (int i = 0; i < 16; i++) begin
      wide = 1'(i);
      av   = $urandom;
      bv   = $urandom >> $urandom_range(0, 31);
      if (i % 5 == 0) bv = 0;
      xact(wide, av, bv, int'($urandom_range(0, 2)), 1'b1, "rnd");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/n_bit_div.md
N_BIT_DIV -- requirements
Module: n_bit_div

Interface
REQ-001 SHALL have parameter BIT_DEPTH, default 32, operand width; legal values are even and at least 2.
REQ-002 SHALL have port clk, input, 1, single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst_n, input, 1, reset; asynchronous, active-low.
REQ-004 SHALL have port in_valid, input, 1, dividend/divisor offered.
REQ-005 SHALL have port in_ready, output, 1, block can accept operands.
REQ-006 SHALL have port a, input, BIT_DEPTH, unsigned dividend.
REQ-007 SHALL have port b, input, BIT_DEPTH, unsigned divisor.
REQ-008 SHALL have port out_valid, output, 1, result available.
REQ-009 SHALL have port out_ready, input, 1, consumer takes the result.
REQ-010 SHALL have port q, output, BIT_DEPTH, quotient floor(a/b).
REQ-011 SHALL have port r, output, BIT_DEPTH, remainder a - q*b.

Function
REQ-012 SHALL be a unsigned restoring divider with one quotient bit per cycle, MSB first, and a FSM with states IDLE, CALC and DONE.
REQ-013 SHALL drive in_ready high only in IDLE and out_valid high only in DONE; both outputs are registered or decoded from state only.
REQ-014 SHALL accept operands on an edge with in_valid and in_ready both high, capture a and b, clear the partial remainder, and enter CALC.
REQ-015 SHALL, on each CALC edge, shift {rem, dividend-MSB} left, subtract b using a BIT_DEPTH+1-bit difference, restore if negative, and shift the quotient bit in.
REQ-016 SHALL complete after exactly BIT_DEPTH CALC edges, so out_valid rises BIT_DEPTH cycles after the acceptance edge, with q and r written on that edge.
REQ-017 SHALL hold q, r and out_valid stable in DONE while out_ready is low, with no limit on wait time.
REQ-018 SHALL return to IDLE on a DONE edge with out_ready high; in_ready rises the next cycle, and there is no same-cycle result-out/operand-in overlap.
REQ-019 SHALL ignore a, b and in_valid outside IDLE; operand changes during CALC do not affect the result.
REQ-020 SHALL produce q = all-ones and r = a for b = 0, which is the natural restoring result, taking full latency when the macro is absent.
REQ-021 SHALL keep q and r at their last result values in IDLE and CALC, with no glitching to intermediate values.

Reset
REQ-022 SHALL, when rst_n is low, immediately force state IDLE, q = 0, r = 0, out_valid = 0, in_ready = 1 after release, and clear internal registers.
REQ-023 SHALL abandon an in-flight operation on reset mid-CALC or mid-DONE, with no result delivered after release.
REQ-024 SHALL accept operands on the first clock edge after deassertion when in_valid is high.

Configuration
REQ-025 SHALL, with macro N_BIT_DIV_ZERO_DET_EN defined, add output port div_zero, 1 bit, valid with out_valid.
REQ-026 SHALL, with N_BIT_DIV_ZERO_DET_EN defined and b = 0 on acceptance, skip CALC and enter DONE on the next edge (out_valid 1 cycle after acceptance) with q = all-ones, r = a and div_zero = 1.
REQ-027 SHALL hold div_zero at 0 for nonzero divisors and reset it to 0.
REQ-028 SHALL, without N_BIT_DIV_ZERO_DET_EN, have no div_zero port and follow REQ-020; nonzero-divisor behaviour is identical in both builds.

Verification
REQ-029 SHALL cover: BIT_DEPTH=8, a=100, b=7, out_ready=1 -> out_valid 8 cycles after acceptance, q=14, r=2, in_ready high the following cycle.
REQ-030 SHALL cover: BIT_DEPTH=8, a=255/b=1, a=5/b=10 and a=0/b=3 -> (255,0), (0,5) and (0,0).
REQ-031 SHALL cover: BIT_DEPTH=32, a=0xFFFFFFFF, b=0x10000 -> q=0xFFFF, r=0xFFFF after 32 cycles; out_ready held low 5 cycles -> q/r/out_valid stable, in_ready low throughout.
REQ-032 SHALL cover: BIT_DEPTH=8, a=37, b=0 -> without macro q=255, r=37 after 8 cycles; with macro q=255, r=37, div_zero=1 after 1 cycle.
REQ-033 SHALL cover: rst_n pulsed low at CALC cycle 4 -> outputs zero asynchronously, no out_valid afterwards; new operands 20/6 then yield q=3, r=2.
REQ-034 SHALL cover: randomized a/b changes during CALC plus in_valid held high in DONE -> result matches the captured operands and exactly one result per acceptance.
